// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I memory-access controller:
// opcode constants, FSM state encoding and a memory-opcode helper.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_mem_opcode(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable up/down wait counter with a terminal-match flag; counts down
// for fixed latencies and up toward the timeout in ready mode.
module wait_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             step,
    input  logic             up,
    input  logic [CNT_W-1:0] term_val,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (step) begin
            cnt <= up ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
        end
    end

    assign at_term = (cnt == term_val);

endmodule

// File: rtl/mem_access_ctrl.sv
// Holds the PC and gates register writeback while an RV32I load/store completes.
// Define MEM_ACCESS_PERF_EN to add the stall_cycles / access_count counters.
module mem_access_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int LOAD_LAT  = 2,
    parameter int STORE_LAT = 1,
    parameter int USE_READY = 0,
    parameter int MAX_WAIT  = 64,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        inst_valid,
    input  logic        mem_ready,
    output logic        pc_enable,
    output logic        reg_write_gate,
    output logic        mem_req,
    output logic        mem_we,
    output logic        busy,
    output logic        bus_err
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] access_count
`endif
);

    localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] STORE_CNT = CNT_W'(STORE_LAT);
    localparam logic [CNT_W-1:0] TERM_CNT  = (USE_READY != 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    state_t           state;
    logic             is_store;
    logic             mem_op;
    logic             op_store;
    logic [CNT_W-1:0] lat;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_step;
    logic             at_term;

    assign mem_op   = inst_valid && is_mem_opcode(opcode);
    assign op_store = (opcode == OP_STORE);
    assign lat      = op_store ? STORE_CNT : LOAD_CNT;

    // Fixed mode loads L-1 and counts down to 0; ready mode counts up from 0 to the timeout.
    assign cnt_load = (state == IDLE) && mem_op;
    assign cnt_val  = (USE_READY != 0) ? '0 : lat - CNT_W'(1);
    assign cnt_step = (state == WAIT) && !at_term && !((USE_READY != 0) && mem_ready);

    wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .step     (cnt_step),
        .up       (USE_READY != 0),
        .term_val (TERM_CNT),
        .at_term  (at_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            is_store <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        is_store <= op_store;
                        state    <= ((USE_READY == 0) && (lat == '0)) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (USE_READY != 0) begin
                        if (mem_ready) begin
                            state <= DONE;
                        end else if (at_term) begin
                            bus_err <= 1'b1;
                            state   <= DONE;
                        end
                    end else if (at_term) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // IDLE issue is combinational so non-memory ops advance in a single cycle.
    always_comb begin
        pc_enable      = 1'b0;
        reg_write_gate = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        busy           = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem_req = 1'b1;
                        mem_we  = op_store;
                    end else if (inst_valid) begin
                        pc_enable      = 1'b1;
                        reg_write_gate = 1'b1;
                    end
                end
                DONE: begin
                    pc_enable      = 1'b1;
                    reg_write_gate = !is_store;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            access_count <= '0;
        end else begin
            if (busy && !pc_enable && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (mem_req && (access_count != '1))
                access_count <= access_count + 32'd1;
        end
    end
`endif

endmodule
